// File: rtl/mantle_stream_pkg.sv
// mantle_stream_pkg: shared FSM state type and index-width helper for the mantle stream blocks.
package mantle_stream_pkg;

    typedef enum logic {IDLE, SEND} state_e;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mantle_beat_counter.sv
// mantle_beat_counter: modulo-DEPTH counter with enable, clear (priority) and terminal count.
module mantle_beat_counter
    import mantle_stream_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      clr_i,
    output logic [idx_w(DEPTH)-1:0]   cnt_o,
    output logic                      tc_o
);

    localparam int IDX_W = idx_w(DEPTH);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc_o  = cnt_q == IDX_W'(DEPTH - 1);
        cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + IDX_W'(1)) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mantle_array_serializer.sv
// mantle_array_serializer: captures a DEPTH-word array and streams it out word 0 first over valid/ready,
// accepting the next array on the last beat so back-to-back arrays flow without a bubble.
module mantle_array_serializer
    import mantle_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 15
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [DEPTH-1:0][WIDTH-1:0]      I,
    input  logic                             I_valid,
    output logic                             I_ready,
    output logic [WIDTH-1:0]                 O,
    output logic                             O_valid,
    input  logic                             O_ready,
    output logic                             O_last,
    output logic [idx_w(DEPTH)-1:0]          O_index
);

    localparam int IDX_W = idx_w(DEPTH);

    if (DEPTH < 2) begin : g_depth_chk
        $error("mantle_array_serializer: DEPTH must be at least 2");
    end

    state_e                        state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]              idx;
    logic                          tc;
    logic                          send;
    logic                          last_beat;
    logic                          accept;
    logic                          cnt_en;

    mantle_beat_counter #(.DEPTH(DEPTH)) u_cnt (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (cnt_en),
        .clr_i (accept),
        .cnt_o (idx),
        .tc_o  (tc)
    );

    // I_ready is the only combinational output; it sees O_ready solely on the last beat.
    always_comb begin
        send      = state_q == SEND;
        last_beat = send && O_ready && tc;
        I_ready   = !RESET && (!send || last_beat);
        accept    = I_valid && I_ready;
        cnt_en    = send && O_ready;
        state_d   = accept ? SEND : last_beat ? IDLE : state_q;
        buf_d     = accept ? I : buf_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    assign O       = buf_q[idx];
    assign O_valid = send;
    assign O_last  = send && tc;
    assign O_index = idx;

endmodule
